// File: rtl/ece331_lab2.sv
// ece331_lab2 -- single-cycle RISC-V style datapath slice.
//
// Holds a 32 x 32-bit register file (x0 hard-wired to zero), an ALU with
// R/I-type decode, and a 32 x 32-bit word-addressed data memory.  Register
// and memory writes commit on the rising clock edge; all reads, the ALU and
// the status flags are combinational.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   write               global register-file write enable
//   rs1, rs2, rd        source / destination register indices
//   RegWrite            writeback enable
//   ALUSrc              operand B select: 0 = reg[rs2], 1 = sign-extended imm
//   PCSrc               branch instruction flag
//   MemRead, MemWrite   data-memory read / write enables
//   MemToReg            writeback select: 0 = ALU result, 1 = memory data
//   ALUOp0, ALUOp1      ALU op class: 00 add, 01 sub, 10 R-type, 11 I-type
//   func3, func5        funct3 / funct7 fields
//   imm                 12-bit signed immediate
//   data                status: [0] ALU zero, [1] branch taken
//   rv1, rv2            reg[rs1], reg[rs2]
module ece331_lab2 (
  input  logic        clk,
  input  logic        reset,
  input  logic        write,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [4:0]  rd,
  input  logic        RegWrite,
  input  logic        ALUSrc,
  input  logic        PCSrc,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        MemToReg,
  input  logic        ALUOp0,
  input  logic        ALUOp1,
  input  logic [2:0]  func3,
  input  logic [6:0]  func5,
  input  logic [11:0] imm,
  output logic [1:0]  data,
  output logic [31:0] rv1,
  output logic [31:0] rv2
);

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND
  } alu_op_e;

  logic [31:0] regs [32];
  logic [31:0] mem  [32];

  alu_op_e     alu_op;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  shamt;
  logic [31:0] alu_result;
  logic        zero;
  logic [4:0]  mem_addr;
  logic [31:0] mem_rdata;
  logic [31:0] wb_value;

  // Only func5[5] carries meaning for this ALU.
  logic unused_func5;
  assign unused_func5 = ^{func5[6], func5[4:0]};

  // Register reads; x0 is forced to zero so it never depends on storage.
  assign rv1 = (rs1 == 5'd0) ? '0 : regs[rs1];
  assign rv2 = (rs2 == 5'd0) ? '0 : regs[rs2];

  assign op_a  = rv1;
  assign op_b  = ALUSrc ? {{20{imm[11]}}, imm} : rv2;
  assign shamt = op_b[4:0];

  // R-type honours func5[5] for add/sub and srl/sra; I-type only for
  // srl/sra, since addi has no subtract form.
  always_comb begin
    alu_op = ALU_ADD;
    case ({ALUOp1, ALUOp0})
      2'b00: alu_op = ALU_ADD;
      2'b01: alu_op = ALU_SUB;
      default: begin
        case (func3)
          3'b000: alu_op = (func5[5] && !ALUOp0) ? ALU_SUB : ALU_ADD;
          3'b001: alu_op = ALU_SLL;
          3'b010: alu_op = ALU_SLT;
          3'b011: alu_op = ALU_SLTU;
          3'b100: alu_op = ALU_XOR;
          3'b101: alu_op = func5[5] ? ALU_SRA : ALU_SRL;
          3'b110: alu_op = ALU_OR;
          default: alu_op = ALU_AND;
        endcase
      end
    endcase
  end

  always_comb begin
    alu_result = '0;
    case (alu_op)
      ALU_ADD:  alu_result = op_a + op_b;
      ALU_SUB:  alu_result = op_a - op_b;
      ALU_SLL:  alu_result = op_a << shamt;
      ALU_SLT:  alu_result = {31'b0, ($signed(op_a) < $signed(op_b))};
      ALU_SLTU: alu_result = {31'b0, (op_a < op_b)};
      ALU_XOR:  alu_result = op_a ^ op_b;
      ALU_SRL:  alu_result = op_a >> shamt;
      ALU_SRA:  alu_result = $signed(op_a) >>> shamt;
      ALU_OR:   alu_result = op_a | op_b;
      ALU_AND:  alu_result = op_a & op_b;
      default:  alu_result = '0;
    endcase
  end

  assign zero = (alu_result == '0);
  assign data = {PCSrc & zero, zero};

  // Word address; byte offset and upper bits are dropped so it wraps.
  assign mem_addr  = alu_result[6:2];
  assign mem_rdata = MemRead ? mem[mem_addr] : '0;
  assign wb_value  = MemToReg ? mem_rdata : alu_result;

  // Both writes sample pre-edge values, so a store and a register write
  // in the same cycle never see each other's result.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < 32; i++) begin
        regs[5'(i)] <= '0;
        mem[5'(i)]  <= '0;
      end
    end else begin
      if (MemWrite)
        mem[mem_addr] <= rv2;
      if (write && RegWrite && (rd != 5'd0))
        regs[rd] <= wb_value;
    end
  end

endmodule

// File: tb/tb_ece331_lab2.sv
// Directed, table-driven bench for ece331_lab2.  Each record sets up one
// instruction, checks rv1/rv2/data just before the rising edge, then lets
// the edge commit it.  Expected values are hand-computed.
module tb_ece331_lab2;

  logic        clk = 1'b0;
  logic        reset;
  logic        write;
  logic [4:0]  rs1, rs2, rd;
  logic        RegWrite, ALUSrc, PCSrc, MemRead, MemWrite, MemToReg;
  logic        ALUOp0, ALUOp1;
  logic [2:0]  func3;
  logic [6:0]  func5;
  logic [11:0] imm;
  logic [1:0]  data;
  logic [31:0] rv1, rv2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ece331_lab2 dut (
    .clk(clk), .reset(reset), .write(write),
    .rs1(rs1), .rs2(rs2), .rd(rd),
    .RegWrite(RegWrite), .ALUSrc(ALUSrc), .PCSrc(PCSrc),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemToReg(MemToReg),
    .ALUOp0(ALUOp0), .ALUOp1(ALUOp1),
    .func3(func3), .func5(func5), .imm(imm),
    .data(data), .rv1(rv1), .rv2(rv2)
  );

  typedef struct packed {
    logic        wr;
    logic        rw;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        asrc;
    logic        pcs;
    logic        mrd;
    logic        mwr;
    logic        m2r;
    logic [1:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f5;
    logic [11:0] imm;
    logic [31:0] e1;
    logic [31:0] e2;
    logic [1:0]  ed;
  } vec_t;

  vec_t vecs [33];

  function automatic vec_t mk(input logic wr, input logic rw,
                              input logic [4:0] a, input logic [4:0] b,
                              input logic [4:0] d, input logic asrc,
                              input logic pcs, input logic mrd,
                              input logic mwr, input logic m2r,
                              input logic [1:0] op, input logic [2:0] f3,
                              input logic [6:0] f5, input logic [11:0] im,
                              input logic [31:0] e1, input logic [31:0] e2,
                              input logic [1:0] ed);
    vec_t v;
    v.wr = wr; v.rw = rw; v.rs1 = a; v.rs2 = b; v.rd = d;
    v.asrc = asrc; v.pcs = pcs; v.mrd = mrd; v.mwr = mwr; v.m2r = m2r;
    v.op = op; v.f3 = f3; v.f5 = f5; v.imm = im;
    v.e1 = e1; v.e2 = e2; v.ed = ed;
    return v;
  endfunction

  task automatic check(input string name, input int idx,
                       input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s [%0d]: got %h, expected %h", name, idx, got, want);
    end
  endtask

  task automatic drive(input vec_t v);
    write = v.wr; RegWrite = v.rw; rs1 = v.rs1; rs2 = v.rs2; rd = v.rd;
    ALUSrc = v.asrc; PCSrc = v.pcs; MemRead = v.mrd; MemWrite = v.mwr;
    MemToReg = v.m2r; {ALUOp1, ALUOp0} = v.op; func3 = v.f3;
    func5 = v.f5; imm = v.imm;
  endtask

  // Called 1 time unit after a rising edge; checks mid-cycle, then commits.
  task automatic apply(input vec_t v, input int idx);
    drive(v);
    #4;
    check("rv1", idx, rv1, v.e1);
    check("rv2", idx, rv2, v.e2);
    check("data", idx, {30'b0, data}, {30'b0, v.ed});
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(mk(0,0, 0,0,0, 1,0,0,0,0, 2'b00,3'b000,7'h00,12'd0, '0,'0,2'b00));
  endtask

  task automatic check_all_zero(input int tag);
    for (int i = 0; i < 32; i++) begin
      rs1 = 5'(i);
      rs2 = 5'(31 - i);
      #1;
      check("rv1_zero", tag * 100 + i, rv1, 32'd0);
      check("rv2_zero", tag * 100 + i, rv2, 32'd0);
    end
  endtask

  initial begin
    vecs[0]  = mk(1,1, 0,0,5,   1,0,0,0,0, 2'b11,3'b000,7'h00,12'd12,  32'd0,        32'd0,        2'b00);
    vecs[1]  = mk(1,1, 0,5,6,   1,0,0,0,0, 2'b11,3'b000,7'h00,12'd30,  32'd0,        32'd12,       2'b00);
    vecs[2]  = mk(1,1, 5,6,7,   0,0,0,0,0, 2'b10,3'b000,7'h00,12'd0,   32'd12,       32'd30,       2'b00);
    vecs[3]  = mk(1,1, 5,6,8,   0,0,0,0,0, 2'b10,3'b000,7'h20,12'd0,   32'd12,       32'd30,       2'b00);
    vecs[4]  = mk(1,1, 8,7,9,   1,0,0,0,0, 2'b11,3'b101,7'h20,12'd1,   32'hFFFFFFEE, 32'd42,       2'b00);
    vecs[5]  = mk(1,1, 8,9,12,  1,0,0,0,0, 2'b11,3'b101,7'h00,12'd1,   32'hFFFFFFEE, 32'hFFFFFFF7, 2'b00);
    vecs[6]  = mk(1,1, 0,12,0,  1,0,0,0,0, 2'b11,3'b000,7'h00,12'd5,   32'd0,        32'h7FFFFFF7, 2'b00);
    vecs[7]  = mk(0,1, 0,0,5,   1,0,0,0,0, 2'b11,3'b000,7'h00,12'd99,  32'd0,        32'd0,        2'b00);
    vecs[8]  = mk(1,0, 0,7,0,   1,0,0,1,0, 2'b00,3'b000,7'h00,12'd8,   32'd0,        32'd42,       2'b00);
    vecs[9]  = mk(1,1, 0,5,10,  1,0,1,0,1, 2'b00,3'b000,7'h00,12'd8,   32'd0,        32'd12,       2'b00);
    vecs[10] = mk(0,0, 5,5,0,   0,1,0,0,0, 2'b01,3'b000,7'h00,12'd0,   32'd12,       32'd12,       2'b11);
    vecs[11] = mk(0,0, 5,6,0,   0,1,0,0,0, 2'b01,3'b000,7'h00,12'd0,   32'd12,       32'd30,       2'b00);
    vecs[12] = mk(1,1, 8,5,11,  0,0,0,0,0, 2'b10,3'b010,7'h00,12'd0,   32'hFFFFFFEE, 32'd12,       2'b00);
    vecs[13] = mk(1,1, 8,5,13,  0,0,0,0,0, 2'b10,3'b011,7'h00,12'd0,   32'hFFFFFFEE, 32'd12,       2'b01);
    vecs[14] = mk(1,1, 5,6,14,  0,0,0,0,0, 2'b10,3'b100,7'h00,12'd0,   32'd12,       32'd30,       2'b00);
    vecs[15] = mk(1,1, 5,6,15,  0,0,0,0,0, 2'b10,3'b110,7'h00,12'd0,   32'd12,       32'd30,       2'b00);
    vecs[16] = mk(1,1, 5,6,16,  0,0,0,0,0, 2'b10,3'b111,7'h00,12'd0,   32'd12,       32'd30,       2'b00);
    vecs[17] = mk(1,1, 5,10,17, 1,0,0,0,0, 2'b11,3'b001,7'h00,12'd3,   32'd12,       32'd42,       2'b00);
    vecs[18] = mk(0,0, 10,11,0, 1,0,0,0,0, 2'b00,3'b000,7'h00,12'd0,   32'd42,       32'd1,        2'b00);
    vecs[19] = mk(0,0, 14,15,0, 1,0,0,0,0, 2'b00,3'b000,7'h00,12'd0,   32'd18,       32'd30,       2'b00);
    vecs[20] = mk(0,0, 16,17,0, 1,0,0,0,0, 2'b00,3'b000,7'h00,12'd0,   32'd12,       32'd96,       2'b00);
    vecs[21] = mk(0,0, 13,9,0,  1,0,0,0,0, 2'b00,3'b000,7'h00,12'd0,   32'd0,        32'hFFFFFFF7, 2'b01);
    vecs[22] = mk(0,0, 12,0,0,  1,0,0,0,0, 2'b00,3'b000,7'h00,12'd0,   32'h7FFFFFF7, 32'd0,        2'b00);
    vecs[23] = mk(1,1, 5,0,18,  1,0,0,0,0, 2'b11,3'b000,7'h20,12'd1,   32'd12,       32'd0,        2'b00);
    vecs[24] = mk(1,1, 5,18,19, 1,0,0,0,0, 2'b11,3'b000,7'h00,12'hFEC, 32'd12,       32'd13,       2'b00);
    vecs[25] = mk(0,0, 5,19,0,  1,0,0,0,0, 2'b00,3'b000,7'h00,12'hFF4, 32'd12,       32'hFFFFFFF8, 2'b01);
    vecs[26] = mk(1,1, 0,5,5,   1,0,0,1,0, 2'b00,3'b000,7'h00,12'd4,   32'd0,        32'd12,       2'b00);
    vecs[27] = mk(1,1, 0,5,20,  1,0,1,0,1, 2'b00,3'b000,7'h00,12'd4,   32'd0,        32'd4,        2'b00);
    vecs[28] = mk(0,0, 20,5,0,  1,0,0,0,0, 2'b00,3'b000,7'h00,12'd0,   32'd12,       32'd4,        2'b00);
    vecs[29] = mk(1,1, 5,5,5,   1,0,0,0,0, 2'b11,3'b000,7'h00,12'd1,   32'd4,        32'd4,        2'b00);
    vecs[30] = mk(0,0, 5,20,0,  1,0,0,0,0, 2'b00,3'b000,7'h00,12'd0,   32'd5,        32'd12,       2'b00);
    vecs[31] = mk(1,1, 0,0,21,  1,0,0,0,1, 2'b00,3'b000,7'h00,12'd4,   32'd0,        32'd0,        2'b00);
    vecs[32] = mk(0,0, 21,7,0,  1,0,0,0,0, 2'b00,3'b000,7'h00,12'd0,   32'd0,        32'd42,       2'b01);

    // Power-up reset.
    reset = 1'b1;
    idle();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_all_zero(1);
    rs1 = 5'd0;
    rs2 = 5'd0;
    #1;
    check("reset_data", 0, {30'b0, data}, 32'd1);
    @(posedge clk);
    #1;

    for (int i = 0; i < 33; i++)
      apply(vecs[i], i);

    // Mid-sequence reset with a register and memory write pending.
    drive(mk(1,1, 0,7,22, 1,0,0,1,0, 2'b11,3'b000,7'h00,12'd8, '0,'0,2'b00));
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle();
    check_all_zero(2);
    rs1 = 5'd0;
    rs2 = 5'd0;
    #1;
    check("reset2_data", 0, {30'b0, data}, 32'd1);
    @(posedge clk);
    #1;

    // lw x10,8(x0) after reset must return zero.
    apply(mk(1,1, 0,0,10, 1,0,1,0,1, 2'b00,3'b000,7'h00,12'd8, 32'd0,32'd0,2'b00), 200);
    apply(mk(0,0, 10,22,0, 1,0,0,0,0, 2'b00,3'b000,7'h00,12'd0, 32'd0,32'd0,2'b01), 201);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ece331_lab2.md
ECE331_LAB2 -- requirements
Module: ece331_lab2

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high; ports clk, reset.
REQ-002 SHALL provide these ports, clock and reset first:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- write  in  1  global register-file write enable.
- rs1  in  5  source register 1 index.
- rs2  in  5  source register 2 index.
- rd  in  5  destination register index.
- RegWrite  in  1  writeback enable.
- ALUSrc  in  1  ALU operand B select: 0 = reg[rs2], 1 = imm.
- PCSrc  in  1  branch instruction flag.
- MemRead  in  1  data-memory read enable.
- MemWrite  in  1  data-memory write enable.
- MemToReg  in  1  writeback select: 0 = ALU, 1 = memory.
- ALUOp0  in  1  ALU op code bit 0.
- ALUOp1  in  1  ALU op code bit 1.
- func3  in  3  RISC-V funct3.
- func5  in  7  RISC-V funct7.
- imm  in  12  signed immediate.
- data  out  2  status: [0] = ALU zero, [1] = branch taken.
- rv1  out  32  reg[rs1].
- rv2  out  32  reg[rs2].

Function
REQ-003 SHALL contain 32 x 32-bit registers; x0 reads 0 always, writes ignored.
REQ-004 rv1/rv2 SHALL be combinational reads; no write-to-read bypass, so the old value shows until the edge.
REQ-005 ALU operand A = reg[rs1]; operand B = ALUSrc ? sign-extended imm : reg[rs2].
REQ-006 ALU op from {ALUOp1,ALUOp0}:
- 00 = add.
- 01 = sub.
- 10 = R-type decode per REQ-007.
- 11 = I-type decode per REQ-007, with func5[5] honoured only for func3=101.
REQ-007 R/I decode by func3:
- 000: add; sub when func5[5]=1 (R-type only).
- 001: sll.
- 010: slt (signed, result 0/1).
- 011: sltu.
- 100: xor.
- 101: srl, or sra when func5[5]=1.
- 110: or.
- 111: and.
REQ-008 Shift amount SHALL be operand B[4:0]; all arithmetic SHALL be 32-bit modulo 2^32, with overflow ignored.
REQ-009 data[0] SHALL equal 1 when the ALU result is 0; data[1] SHALL equal PCSrc & data[0]; both combinational.
REQ-010 SHALL contain a 32 x 32-bit data memory, word address = ALU result[6:2]; upper bits and result[1:0] ignored (wrap-around).
REQ-011 On rising clk with MemWrite=1 and reset=0, mem[addr] SHALL be loaded with reg[rs2].
REQ-012 Memory read data SHALL be combinational: mem[addr] when MemRead=1, else 0.
REQ-013 Writeback value SHALL be MemToReg ? memory read data : ALU result.
REQ-014 On rising clk with reset=0, write=1, RegWrite=1 and rd!=0, reg[rd] SHALL take the writeback value; latency is one edge.
REQ-015 Simultaneous MemWrite and register write SHALL both occur on the same edge, using pre-edge values.
REQ-016 rd=rs1 or rd=rs2 SHALL use the old value as the operand; the new value is visible after the edge.

Reset
REQ-017 While reset=1 at a rising edge, all registers and all memory words SHALL become 0; writes that edge are suppressed.
REQ-018 After reset, rv1=rv2=0 for every index, and data=2'b01 when ALUOp=00 with imm=0.
REQ-019 Reset asserted mid-sequence SHALL discard all state at that edge; no partial writes.

Verification
REQ-020 addi x5,x0,12 then addi x6,x0,30 (ALUSrc=1, ALUOp=11, func3=000, RegWrite=write=1), then add x7,x5,x6 (ALUOp=10, func5=0) -> rs1=7 gives rv1=42.
REQ-021 sub x8,x5,x6 (func5=0100000) -> reg[8] = 0xFFFFFFEE; sra x9,x8,imm=1 -> 0xFFFFFFF7; srl -> 0x7FFFFFF7.
REQ-022 addi x0,x0,5 -> rv1 with rs1=0 stays 0; write=0 with RegWrite=1 -> target register unchanged.
REQ-023 sw x7,8(x0) (ALUOp=00, ALUSrc=1, MemWrite=1, RegWrite=0), then lw x10,8(x0) (MemRead=MemToReg=RegWrite=1) -> reg[10]=42.
REQ-024 beq x5,x5 (ALUOp=01, PCSrc=1) -> data=2'b11; beq x5,x6 -> data=2'b00; slt x11,x8,x5 -> 1, sltu -> 0.
REQ-025 Assert reset for one edge after the above -> all rv reads 0, and the lw of address 8 returns 0.
